d2f_arbiter: RTL

Shares one `double_to_float` converter among N requesters using the converter's stb/ack handshake on both sides. Each requester submits a 64-bit IEEE-754 double and receives its 32-bit float result on its own response channel. The block applies fair round-robin arbitration and a watchdog that recovers a hung converter. It sits between client blocks and the single converter instance, which otherwise serves one master only.

---
 rtl/d2f_pkg.sv | 23 ++
 rtl/d2f_arbiter_rr_arbiter.sv | 43 ++++
 rtl/d2f_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/d2f_pkg.sv
// d2f_pkg: shared types and constants for the double-to-float converter arbiter.
//   d2f_state_e   - arbiter FSM state encoding
//   QNAN32        - result returned to a requester when the converter hangs
//   CV_RST_CYCLES - number of cycles the converter reset is held during recovery
//   sat_inc8      - saturating 8-bit increment for event counters
package d2f_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DELIVER,
        RECOVER
    } d2f_state_e;

    localparam logic [31:0] QNAN32        = 32'h7FC00000;
    localparam int          CV_RST_CYCLES = 2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/d2f_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req   in  N   request vector
//   last  in  IW  index granted most recently; the search starts at last+1
//   grant out N   one-hot winner (all zero when no request)
//   idx   out IW  encoded winner
//   any   out 1   at least one request present
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] kk;

    // Walk N candidates starting one past the previous winner; the first
    // requester met wins, so the previous winner is examined last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        kk    = '0;
        for (int off = 1; off <= N; off++) begin
            sum = {1'b0, last} + (IW+1)'(off);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            kk = sum[IW-1:0];
            if (!any && req[kk]) begin
                any       = 1'b1;
                grant[kk] = 1'b1;
                idx       = kk;
            end
        end
    end

endmodule

// File: rtl/d2f_arbiter.sv
// d2f_arbiter: shares one double_to_float converter among N requesters.
//   clk, rst            clock, synchronous active-high reset
//   req_a/stb/ack       per-requester 64-bit operand channels
//   rsp_z/err/stb/ack   shared result bus with per-requester strobes/acks
//   cv_a/stb/ack        converter input channel
//   cv_z/stb/ack        converter output channel
//   cv_rst              converter reset, pulsed by the watchdog only
//   busy                an operation is in flight
//   timeout_cnt         saturating count of watchdog recoveries
//
// state   | meaning
// IDLE    | offering req_ack to the round-robin winner
// ISSUE   | presenting latched operand to converter
// WAIT    | waiting for converter result
// DELIVER | presenting result to granted requester
// RECOVER | converter hung; holding cv_rst, then returning QNaN with err
module d2f_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*64-1:0] req_a,
    input  logic [N-1:0]    req_stb,
    output logic [N-1:0]    req_ack,
    output logic [31:0]     rsp_z,
    output logic            rsp_err,
    output logic [N-1:0]    rsp_stb,
    input  logic [N-1:0]    rsp_ack,
    output logic [63:0]     cv_a,
    output logic            cv_a_stb,
    input  logic            cv_a_ack,
    input  logic [31:0]     cv_z,
    input  logic            cv_z_stb,
    output logic            cv_z_ack,
    output logic            cv_rst,
    output logic            busy,
    output logic [7:0]      timeout_cnt
);
    import d2f_pkg::*;

    localparam int IW   = $clog2(N);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = $clog2(CV_RST_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(CV_RST_CYCLES - 1);

    d2f_state_e    state_q, state_d;
    logic [IW-1:0] g_q, last_q;
    logic [63:0]   op_q;
    logic [31:0]   res_q;
    logic          err_q;
    logic [WD_W-1:0] wd_q;
    logic [RC_W-1:0] rc_q;
    logic [7:0]    tcnt_q;

    logic [N-1:0]  arb_grant;
    logic [IW-1:0] arb_idx;
    logic          arb_any;

    logic grant_take, z_take, rec_done, rsp_done, wd_fire;

    rr_arbiter #(.N(N)) u_arb (
        .req   (req_stb),
        .last  (last_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // wd_q counts cycles already spent in ISSUE/WAIT; firing on TIMEOUT-1
    // bounds the stay at exactly TIMEOUT cycles.
    assign wd_fire = ((state_q == ISSUE) || (state_q == WAIT)) && (wd_q == WD_LAST);

    always_comb begin
        state_d    = state_q;
        req_ack    = '0;
        rsp_stb    = '0;
        cv_a_stb   = 1'b0;
        cv_z_ack   = 1'b0;
        cv_rst     = 1'b0;
        grant_take = 1'b0;
        z_take     = 1'b0;
        rec_done   = 1'b0;
        rsp_done   = 1'b0;
        case (state_q)
            IDLE: begin
                // Suppressed during reset so no requester sees a phantom accept.
                if (!rst) begin
                    req_ack = arb_grant;
                end
                if (arb_any) begin
                    grant_take = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cv_a_stb = 1'b1;
                if (wd_fire) begin
                    state_d = RECOVER;
                end else if (cv_a_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cv_z_ack = 1'b1;
                if (wd_fire) begin
                    state_d = RECOVER;
                end else if (cv_z_stb) begin
                    z_take  = 1'b1;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                rsp_stb[g_q] = 1'b1;
                if (rsp_ack[g_q]) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            RECOVER: begin
                cv_rst = 1'b1;
                if (rc_q == RC_LAST) begin
                    rec_done = 1'b1;
                    state_d  = DELIVER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= IW'(N - 1);
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            rc_q    <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_take) begin
                g_q  <= arb_idx;
                op_q <= req_a[{arb_idx, 6'd0} +: 64];
                wd_q <= '0;
            end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
                wd_q <= wd_q + WD_W'(1);
            end
            rc_q <= (state_q == RECOVER) ? rc_q + RC_W'(1) : '0;
            if (z_take) begin
                res_q <= cv_z;
                err_q <= 1'b0;
            end
            if (rec_done) begin
                res_q  <= QNAN32;
                err_q  <= 1'b1;
                tcnt_q <= sat_inc8(tcnt_q);
            end
            if (rsp_done) begin
                last_q <= g_q;
            end
        end
    end

    assign rsp_z       = res_q;
    assign rsp_err     = err_q;
    assign cv_a        = op_q;
    assign busy        = (state_q != IDLE);
    assign timeout_cnt = tcnt_q;

endmodule
